// File: rtl/mult_booth_ctrl.sv
// Sequencer around a combinational radix-4 Booth step: 16 steps per multiply, 32-bit signed result.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand completes in one cycle without iterating.
module mult_booth_ctrl #(
  parameter int STEPS = 16,
  parameter int CNT_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: ctrl_MULT is a level start, sampled with the operands on every rising edge it is high
  // (in any state, restarting a running multiply). data_resultRDY is a one-cycle pulse, no back-pressure;
  // data_result/data_exception stay valid until the next completion or reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [64:0]        prod_reg, prod_next;
  logic [31:0]        mcand;
  logic [CNT_W-1:0]   count;
  logic               mplier_01;
  logic               last_step;
  logic               skip_start;
  logic               ovf;

  // The add is done two bits wider than the accumulator so the +/-2M partial product never wraps;
  // after the arithmetic shift by 2 the accumulator fits back into 32 bits.
  function automatic logic [64:0] booth_step(input logic [64:0] p, input logic [31:0] m);
    logic [33:0] acc;
    logic [33:0] pp;
    logic [66:0] wide;
    acc = {{2{p[64]}}, p[64:33]};
    case (p[2:0])
      3'b001, 3'b010: pp = {{2{m[31]}}, m};
      3'b011:         pp = {m[31], m, 1'b0};
      3'b100:         pp = -{m[31], m, 1'b0};
      3'b101, 3'b110: pp = -{{2{m[31]}}, m};
      default:        pp = '0;
    endcase
    acc  = acc + pp;
    wide = {acc, p[32:0]};
    return wide[66:2];
  endfunction

`ifdef MULT_ZERO_SKIP_EN
  assign skip_start = ctrl_MULT && ((data_operandA == 32'd0) || (data_operandB == 32'd0));
`else
  assign skip_start = 1'b0;
`endif

  assign prod_next = booth_step(prod_reg, mcand);
  assign last_step = (state == RUN) && (count == CNT_W'(STEPS - 1));

  // Upper word must be the sign extension of bit 32; a most-negative multiplicand times anything
  // other than 0 or 1 can never fit.
  assign ovf = (~(&prod_next[64:32]) && (|prod_next[64:32])) ||
               ((mcand == 32'h8000_0000) && !mplier_01);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (ctrl_MULT) begin
      next_state = skip_start ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        RUN:     next_state = last_step ? DONE : RUN;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prod_reg       <= '0;
      mcand          <= '0;
      count          <= '0;
      mplier_01      <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      prod_reg  <= {32'd0, data_operandB, 1'b0};
      mcand     <= data_operandA;
      count     <= '0;
      mplier_01 <= (data_operandB[31:1] == 31'd0);
      if (skip_start) begin
        data_result    <= '0;
        data_exception <= 1'b0;
      end
    end else if (state == RUN) begin
      prod_reg <= prod_next;
      count    <= count + CNT_W'(1);
      if (last_step) begin
        data_result    <= prod_next[32:1];
        data_exception <= ovf;
      end
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state == RUN);
  assign dbg_state      = state;

endmodule
